mac_shift_add: RTL
==================

# mac_shift_add

Sequential shift-add multiply-accumulate unit for the neuron datapath. Consumes a stream of (weight, activation) pairs, forms each product by adding left-shifted copies of the weight (one `SLL` pass per activation bit), and accumulates a 16-bit modular dot product. It emits one result per `last`-terminated group to the downstream activation stage.

## Interface
Parameters:
- `ACT_W`, default 8: activation width in bits. Legal range 1..16, because the bit index must fit the 4-bit `SLL` shift port.

Ports:
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `in_valid`, in, 1: the input pair is valid.
- `in_ready`, out, 1: the block can accept a pair.
- `in_weight`, in, 16: weight, two's complement.
- `in_act`, in, `ACT_W`: activation, unsigned.
- `in_last`, in, 1: this pair is the final term of the group.
- `out_valid`, out, 1: a group result is available.
- `out_ready`, in, 1: the downstream stage accepts the result.
- `out_sum`, out, 16: the accumulated sum.
- `out_terms`, out, 8: number of pairs in the group, saturating at 255.

## Operation
- Result definition: `out_sum` = Σ(`in_weight` × `in_act`) mod 2^16, with `in_weight` treated as 16-bit two's complement. All adds wrap and are never saturated.
- FSM state IDLE:
  - `in_ready`=1.
  - When `in_valid`: latch weight, activation and last; set bit index = 0; increment the term count (saturating at 255); go to MUL.
- FSM state MUL, one cycle per activation bit:
  - If `act[idx]`=1, then `acc` ← `acc` + SLL(weight, idx).
  - Then `idx`++.
  - On the cycle that processes `idx` = `ACT_W`−1: go to OUT if last=1, otherwise go to IDLE.
  - Zero activation bits still cost a cycle. There is no early exit.
- FSM state OUT:
  - `out_valid`=1.
  - `out_sum` = `acc` and `out_terms` = count, both held stable.
  - On `out_ready`: clear `acc` and count to 0 and go to IDLE.
- `in_ready`=0 in both MUL and OUT. Input is never accepted during computation or while a result is pending.
- Handshakes follow valid/ready rules:
  - Transfer happens only when valid and ready are both high on the same edge.
  - `out_valid` does not depend combinationally on `out_ready`.
- Reset values: state=IDLE, `acc`=0, count=0, `idx`=0, `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_terms`=0.
- Reset mid-operation: the partial sum and count are discarded immediately; the block is in IDLE after `rst_n` releases.
- `in_last`=1 on the first pair is legal and gives a single-term group.
- The term count saturates at 255; `acc` is unaffected by the saturation.

## Timing
- Accept edge = cycle 0. MUL occupies cycles 1..`ACT_W`.
- For a last pair, `out_valid` rises in cycle `ACT_W`+1 (cycle 9 at the default).
- For a non-last pair, `in_ready` returns high in cycle `ACT_W`+1.
- Throughput: one pair per `ACT_W`+1 cycles, plus output handshake cycles per group.
- `out_ready` held high in the first OUT cycle: `out_valid` is high for exactly one cycle, and IDLE (`in_ready`=1) follows in the next cycle.
- The `SLL` path is combinational and sits between registered `weight`/`idx` and the `acc` adder, giving one adder plus one shifter per clock.

## Structure
- Shared package `nn_pkg`:
  - `DATA_W`=16.
  - `SHIFT_W`=4.
  - FSM enum `mac_state_t` {IDLE, MUL, OUT}.
- Sub-module: one instance of the existing `SLL` barrel shifter.
  - Inputs: `a` = latched weight; `shift` = `idx` zero-extended to 4 bits.
  - Its output feeds the accumulator adder.
- Everything else (FSM, counters, handshake) is local to `mac_shift_add`.

## Test plan
- Single pair, weight=3, act=5, last=1: `out_valid` in cycle 9; `out_sum`=15, `out_terms`=1.
- Group of three pairs (1,1), (2,2), (0xFFFF,4) with last on the third: `out_sum`=0x0001, `out_terms`=3. `in_ready` reopens 9 cycles after each non-last accept.
- Wrap-around:
  - weight=0x4000, act=4: `out_sum`=0x0000.
  - weight=0x0100, act=0xFF: `out_sum`=0xFF00.
  - act=0: `out_sum`=0, and the result still takes 8 MUL cycles.
- Backpressure: hold `out_ready`=0 for 5 cycles, so `out_valid`=1 with a stable sum and `in_ready`=0. Then handshake and run a new group (2,3): `out_sum`=6, showing `acc` was cleared.
- Reset in MUL cycle 4 of (7,0xFF): after release all outputs are 0 and `in_ready`=1. A following group (1,1) gives `out_sum`=1.
- Term saturation: 300 pairs (1,1) with last on the final pair: `out_sum`=300=0x012C, `out_terms`=255.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath blocks.
package nn_pkg;

   localparam int DATA_W   = 16;
   localparam int SHIFT_W  = 4;
   localparam int TERM_W   = 8;
   localparam logic [TERM_W-1:0] TERM_MAX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      OUT  = 2'd2
   } mac_state_t;

   // Increment a term counter, sticking at its all-ones ceiling.
   function automatic logic [TERM_W-1:0] sat_inc(input logic [TERM_W-1:0] v);
      return (v == TERM_MAX) ? v : v + TERM_W'(1);
   endfunction

endpackage

// File: rtl/mac_shift_add_sll.sv
// SLL: combinational logical left barrel shifter.
module SLL
   import nn_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic [W-1:0]       a,
   input  logic [SHIFT_W-1:0] shift,
   output logic [W-1:0]       y
);

   // Shift the operand left, filling with zeros.
   always_comb begin
      y = a << shift;
   end

endmodule

// File: rtl/mac_shift_add.sv
// mac_shift_add: bit-serial shift-add multiply-accumulate, one result per
// last-terminated group of (weight, activation) pairs.
module mac_shift_add
   import nn_pkg::*;
#(
   parameter int ACT_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_weight,
   input  logic [ACT_W-1:0]    in_act,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_sum,
   output logic [TERM_W-1:0]   out_terms
);

   localparam logic [SHIFT_W-1:0] LAST_IDX = SHIFT_W'(ACT_W - 1);

   mac_state_t          state_q;
   logic [DATA_W-1:0]   weight_q;
   logic [DATA_W-1:0]   act_q;      // activation zero-extended so any idx is in range
   logic                last_q;
   logic [SHIFT_W-1:0]  idx_q;
   logic [DATA_W-1:0]   acc_q;
   logic [TERM_W-1:0]   cnt_q;
   logic                in_ready_q;
   logic                out_valid_q;
   logic [DATA_W-1:0]   out_sum_q;
   logic [TERM_W-1:0]   out_terms_q;

   logic [DATA_W-1:0]   shifted;
   logic [DATA_W-1:0]   acc_d;
   logic                last_bit;

   SLL #(.W(DATA_W)) u_sll (
      .a     (weight_q),
      .shift (idx_q),
      .y     (shifted)
   );

   // Next accumulator value for the current activation bit.
   always_comb begin
      acc_d    = acc_q;
      last_bit = (idx_q == LAST_IDX);
      if (act_q[idx_q]) begin
         acc_d = acc_q + shifted;
      end
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         weight_q    <= '0;
         act_q       <= '0;
         last_q      <= 1'b0;
         idx_q       <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_terms_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  weight_q   <= in_weight;
                  act_q      <= DATA_W'(in_act);
                  last_q     <= in_last;
                  idx_q      <= '0;
                  cnt_q      <= sat_inc(cnt_q);
                  in_ready_q <= 1'b0;
                  state_q    <= MUL;
               end
            end
            MUL: begin
               acc_q <= acc_d;
               idx_q <= idx_q + SHIFT_W'(1);
               if (last_bit) begin
                  if (last_q) begin
                     // The result register takes acc_d so the final bit is
                     // included without spending an extra cycle.
                     out_sum_q   <= acc_d;
                     out_terms_q <= cnt_q;
                     out_valid_q <= 1'b1;
                     state_q     <= OUT;
                  end else begin
                     in_ready_q <= 1'b1;
                     state_q    <= IDLE;
                  end
               end
            end
            OUT: begin
               if (out_ready) begin
                  acc_q       <= '0;
                  cnt_q       <= '0;
                  out_valid_q <= 1'b0;
                  out_sum_q   <= '0;
                  out_terms_q <= '0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q    <= IDLE;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Drive ports straight from registers.
   always_comb begin
      in_ready  = in_ready_q;
      out_valid = out_valid_q;
      out_sum   = out_sum_q;
      out_terms = out_terms_q;
   end

endmodule
